adc_sample_dma: RTL and testbench

- Bus initiator on the PicoRV32 native memory interface. It packs 12-bit SAR ADC samples two per 32-bit word and writes them into SoC RAM as a linear buffer or a ring buffer.
- Sits between the SPI SAR ADC front end (sample strobe + data) and the RAM responder, as a second master beside the CPU behind the bus arbiter.
- Firmware programs the start and stop controls and reads back progress through the status outputs.

---
 rtl/adc_dma_pkg.sv | 15 +
 rtl/adc_sample_dma_if.sv | 33 +++
 rtl/adc_sample_dma_sample_packer.sv | 52 +++++
 rtl/adc_sample_dma.sv | 153 +++++++++++++++
 tb/tb_adc_sample_dma.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_dma_pkg.sv
// Shared types and constants for the ADC sample DMA: capture FSM states,
// packing geometry and the fixed write strobe.
package adc_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

  localparam logic [3:0] WSTRB_ALL = 4'hF;
  localparam int         HALF_W    = 16;

endpackage

// File: rtl/adc_sample_dma_if.sv
// PicoRV32 native memory bus as seen by the sample DMA initiator (master)
// and the RAM responder behind the arbiter (slave).
interface adc_sample_dma_if;

  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_instr,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_instr,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/adc_sample_dma_sample_packer.sv
// Pairs zero-extended ADC samples into 32-bit words {second, first}; a word
// that cannot be accepted is dropped and the first half is kept for retry.
module sample_packer
  import adc_dma_pkg::*;
#(
  parameter int SAMPLE_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                accept,
  output logic                word_vld,
  output logic [31:0]         word,
  output logic                drop
);

  logic              half_full;
  logic [HALF_W-1:0] lo_half;
  logic [HALF_W-1:0] sample_ext;
  logic              take;

  assign sample_ext = HALF_W'(sample_data);
  assign take       = enable && sample_valid;
  assign word       = {sample_ext, lo_half};
  assign word_vld   = take && half_full && accept;
  assign drop       = take && half_full && !accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      half_full <= 1'b0;
    end else if (clear) begin
      half_full <= 1'b0;
    end else if (take) begin
      if (!half_full) begin
        half_full <= 1'b1;
      end else if (accept) begin
        half_full <= 1'b0;
      end
    end
  end

  // Low half only loads on the first sample of a pair; a drop leaves it intact.
  always_ff @(posedge clk) begin
    if (take && !half_full) begin
      lo_half <= sample_ext;
    end
  end

endmodule

// File: rtl/adc_sample_dma.sv
// ADC sample DMA: packs sample pairs into words and writes them to a linear
// or ring buffer in RAM as a write-only PicoRV32 native bus master.
module adc_sample_dma
  import adc_dma_pkg::*;
#(
  parameter int          SAMPLE_W  = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int          BUF_WORDS = 256,
  parameter int          CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                circular,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  adc_sample_dma_if.master    bus,
  output logic                busy,
  output logic                done_irq,
  output logic                wrapped,
  output logic [CNT_W-1:0]    words_written,
  output logic [CNT_W-1:0]    drop_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  dma_state_t  state;
  logic        circ_q;
  logic        mem_valid_q;
  logic        wbuf_full;
  logic [31:0] wbuf_data;

  logic        start_acc;
  logic        complete;
  logic        last_word;
  logic        pack_en;
  logic        accept;
  logic        word_vld;
  logic        drop;
  logic [31:0] pack_word;
  logic        unused_rdata;

  assign start_acc = start && !stop && (state == IDLE || state == DONE);
  assign complete  = mem_valid_q && bus.mem_ready;
  assign last_word = (words_written == CNT_W'(BUF_WORDS - 1));
  assign pack_en   = (state == RUN) && !stop;
  assign accept    = !wbuf_full || complete;

  sample_packer #(
    .SAMPLE_W (SAMPLE_W)
  ) u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (!pack_en),
    .enable       (pack_en),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .accept       (accept),
    .word_vld     (word_vld),
    .word         (pack_word),
    .drop         (drop)
  );

  // Control: FSM, write-buffer occupancy, bus request and progress counters.
  // The FSM case comes last so its discards override the buffer bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      circ_q        <= 1'b0;
      mem_valid_q   <= 1'b0;
      wbuf_full     <= 1'b0;
      words_written <= '0;
      drop_cnt      <= '0;
      wrapped       <= 1'b0;
      done_irq      <= 1'b0;
    end else begin
      done_irq <= 1'b0;

      if (complete) begin
        mem_valid_q <= 1'b0;
        wbuf_full   <= 1'b0;
        if (!last_word) begin
          words_written <= words_written + CNT_W'(1);
        end else if (circ_q) begin
          words_written <= '0;
          wrapped       <= 1'b1;
        end
      end else if (wbuf_full && !mem_valid_q && pack_en) begin
        mem_valid_q <= 1'b1;
      end

      if (word_vld) begin
        wbuf_full <= 1'b1;
      end

      if (drop) begin
        drop_cnt <= sat_inc(drop_cnt);
      end

      case (state)
        IDLE, DONE: begin
          if (start_acc) begin
            state         <= RUN;
            circ_q        <= circular;
            words_written <= '0;
            drop_cnt      <= '0;
            wrapped       <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= DRAIN;
            // A word that never reached the bus is abandoned on stop.
            if (!mem_valid_q) begin
              wbuf_full <= 1'b0;
            end
          end else if (complete && last_word && !circ_q) begin
            state     <= DONE;
            done_irq  <= 1'b1;
            wbuf_full <= 1'b0;
          end
        end
        DRAIN: begin
          if (!mem_valid_q || bus.mem_ready) begin
            state    <= DONE;
            done_irq <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data: write buffer contents; stable while the request is outstanding
  // because a new word can only load on the completing edge.
  always_ff @(posedge clk) begin
    if (word_vld) begin
      wbuf_data <= pack_word;
    end
  end

  assign busy          = (state == RUN) || (state == DRAIN);
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = mem_valid_q ? BASE_ADDR + (32'(words_written) << 2) : 32'h0;
  assign bus.mem_wdata = mem_valid_q ? wbuf_data : 32'h0;
  assign bus.mem_wstrb = mem_valid_q ? WSTRB_ALL : 4'h0;
  assign unused_rdata  = ^bus.mem_rdata;

endmodule

// File: tb/tb_adc_sample_dma.sv
// Directed scoreboard bench for adc_sample_dma with a 4-word buffer and a
// responder that answers one cycle after the request unless stalled.
`timescale 1ns/1ps
module tb_adc_sample_dma;

  localparam int          SW   = 12;
  localparam int          NW   = 4;
  localparam int          CW   = 16;
  localparam logic [31:0] BASE = 32'h0000_2000;

  logic          clk          = 1'b0;
  logic          reset        = 1'b1;
  logic          start        = 1'b0;
  logic          stop         = 1'b0;
  logic          circular     = 1'b0;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample_data  = '0;
  logic          busy;
  logic          done_irq;
  logic          wrapped;
  logic [CW-1:0] words_written;
  logic [CW-1:0] drop_cnt;
  logic          stall = 1'b0;

  int            n_checks  = 0;
  int            n_fail    = 0;
  int            done_cnt  = 0;
  int            done_base = 0;
  logic [63:0]   exp_q[$];
  logic [63:0]   t2_exp[4];
  logic [63:0]   t3_exp[5];

  adc_sample_dma_if bus();

  adc_sample_dma #(
    .SAMPLE_W  (SW),
    .BASE_ADDR (BASE),
    .BUF_WORDS (NW),
    .CNT_W     (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .circular      (circular),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .bus           (bus),
    .busy          (busy),
    .done_irq      (done_irq),
    .wrapped       (wrapped),
    .words_written (words_written),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) bus.mem_ready <= 1'b0;
    else       bus.mem_ready <= bus.mem_valid && !bus.mem_ready && !stall;
  end
  assign bus.mem_rdata = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (done_irq) done_cnt++;
      if (!reset && bus.mem_valid && bus.mem_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, required no write",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("write_addr",  64'(bus.mem_addr),  64'(e[63:32]));
          check("write_wdata", 64'(bus.mem_wdata), 64'(e[31:0]));
          check("write_wstrb", 64'(bus.mem_wstrb), 64'hF);
        end
      end
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [SW-1:0] s);
    sample_valid = 1'b1;
    sample_data  = s;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic circ);
    circular = circ;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    exp_q.delete();
    step();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || bus.mem_valid) && k < budget) begin
      step();
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s: %0d writes outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_valid"}, 64'(bus.mem_valid), 64'(0));
    check({tag, "_mem_addr"},  64'(bus.mem_addr),  64'(0));
    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
    check({tag, "_mem_wstrb"}, 64'(bus.mem_wstrb), 64'(0));
    check({tag, "_busy"},      64'(busy),          64'(0));
    check({tag, "_done_irq"},  64'(done_irq),      64'(0));
    check({tag, "_wrapped"},   64'(wrapped),       64'(0));
    check({tag, "_words"},     64'(words_written), 64'(0));
    check({tag, "_drops"},     64'(drop_cnt),      64'(0));
  endtask

  initial begin
    t2_exp[0] = {32'h0000_2000, 32'h0102_0101};
    t2_exp[1] = {32'h0000_2004, 32'h0104_0103};
    t2_exp[2] = {32'h0000_2008, 32'h0106_0105};
    t2_exp[3] = {32'h0000_200C, 32'h0108_0107};
    t3_exp[0] = {32'h0000_2000, 32'h0202_0201};
    t3_exp[1] = {32'h0000_2004, 32'h0204_0203};
    t3_exp[2] = {32'h0000_2008, 32'h0206_0205};
    t3_exp[3] = {32'h0000_200C, 32'h0208_0207};
    t3_exp[4] = {32'h0000_2000, 32'h020A_0209};

    fork
      monitor();
    join_none

    step(2);
    check_idle_outputs("reset");
    check("reset_mem_instr", 64'(bus.mem_instr), 64'(0));
    reset = 1'b0;
    step();

    // Single word: bus timing around load, request and completion.
    pulse_start(1'b0);
    check("t1_busy", 64'(busy), 64'(1));
    send(12'h123);
    send(12'h456);
    exp_q.push_back({32'h0000_2000, 32'h0456_0123});
    check("t1_valid_after_load", 64'(bus.mem_valid), 64'(0));
    step();
    check("t1_valid_rise", 64'(bus.mem_valid), 64'(1));
    check("t1_ready_lag",  64'(bus.mem_ready), 64'(0));
    step(2);
    check("t1_valid_low_after_done", 64'(bus.mem_valid), 64'(0));
    wait_drain("t1_drain", 20);
    check("t1_words", 64'(words_written), 64'(1));

    // One-shot fill of the whole buffer.
    do_reset();
    done_base = done_cnt;
    pulse_start(1'b0);
    for (int i = 0; i < 8; i++) begin
      send(12'(12'h101 + i));
      if (i % 2 == 1) exp_q.push_back(t2_exp[i / 2]);
      step(5);
    end
    wait_drain("t2_drain", 40);
    step(2);
    check("t2_done_pulses", 64'(done_cnt - done_base), 64'(1));
    check("t2_busy", 64'(busy), 64'(0));
    send(12'h109);
    step(6);
    check("t2_drops_after", 64'(drop_cnt), 64'(0));
    check("t2_bus_quiet", 64'(bus.mem_valid), 64'(0));

    // Ring buffer wraps after four words.
    do_reset();
    pulse_start(1'b1);
    for (int i = 0; i < 10; i++) begin
      send(12'(12'h201 + i));
      if (i % 2 == 1) exp_q.push_back(t3_exp[i / 2]);
      step(5);
    end
    wait_drain("t3_drain", 40);
    check("t3_wrapped", 64'(wrapped), 64'(1));
    check("t3_words", 64'(words_written), 64'(1));
    check("t3_busy", 64'(busy), 64'(1));

    // Responder stall: request held, one more pair dropped.
    do_reset();
    stall = 1'b1;
    pulse_start(1'b0);
    send(12'h0AA);
    send(12'h0BB);
    exp_q.push_back({32'h0000_2000, 32'h00BB_00AA});
    step();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 64'(bus.mem_valid), 64'(1));
      check("t4_hold_ready", 64'(bus.mem_ready), 64'(0));
      check("t4_hold_addr",  64'(bus.mem_addr),  64'h2000);
      check("t4_hold_wdata", 64'(bus.mem_wdata), 64'h00BB_00AA);
      if (i == 1)      send(12'h0CC);
      else if (i == 3) send(12'h0DD);
      else             step();
    end
    check("t4_drops", 64'(drop_cnt), 64'(1));
    check("t4_words_stalled", 64'(words_written), 64'(0));
    stall = 1'b0;
    wait_drain("t4_drain1", 20);
    check("t4_words", 64'(words_written), 64'(1));
    send(12'h0EE);
    exp_q.push_back({32'h0000_2004, 32'h00EE_00CC});
    wait_drain("t4_drain2", 20);
    check("t4_drops_final", 64'(drop_cnt), 64'(1));

    // Stop with a write in flight and a half-filled pack word.
    do_reset();
    stall = 1'b1;
    pulse_start(1'b0);
    done_base = done_cnt;
    send(12'h011);
    send(12'h022);
    exp_q.push_back({32'h0000_2000, 32'h0022_0011});
    step();
    send(12'h033);
    pulse_stop();
    check("t5_drain_busy", 64'(busy), 64'(1));
    check("t5_drain_valid", 64'(bus.mem_valid), 64'(1));
    stall = 1'b0;
    wait_drain("t5_drain", 20);
    step(2);
    check("t5_done_pulses", 64'(done_cnt - done_base), 64'(1));
    check("t5_busy", 64'(busy), 64'(0));
    send(12'h044);
    send(12'h055);
    step(6);
    check("t5_bus_quiet", 64'(bus.mem_valid), 64'(0));
    check("t5_words", 64'(words_written), 64'(1));

    // Reset with a request outstanding, then start+stop together in IDLE.
    do_reset();
    stall = 1'b1;
    pulse_start(1'b0);
    send(12'h011);
    send(12'h022);
    step();
    check("t6_valid_before_reset", 64'(bus.mem_valid), 64'(1));
    reset = 1'b1;
    step();
    check_idle_outputs("t6_reset");
    reset = 1'b0;
    exp_q.delete();
    stall = 1'b0;
    step();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    step();
    check("t6_start_stop_idle", 64'(busy), 64'(0));
    pulse_start(1'b0);
    check("t6_start_after", 64'(busy), 64'(1));
    step(4);
    check("t6_bus_quiet", 64'(bus.mem_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
